pid_output_stage: RTL and testbench

//  Downstream of the integrator and the P/D multiplier stages: sums the three signed

---
 rtl/pid_pkg.sv | 23 ++
 rtl/pid_pwm_gen.sv | 49 ++++
 rtl/pid_output_stage.sv | 75 +++++++
 tb/tb_pid_output_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared PID definitions: datapath width and the unsigned duty saturation helper,
// also used by the integrator path for anti-windup.
package pid_pkg;

  localparam int PID_W     = 6;
  localparam int PID_SUM_W = PID_W + 2;

  typedef struct packed {
    logic             hi;
    logic             lo;
    logic [PID_W-1:0] duty;
  } sat_t;

  // Clamp a signed PID_SUM_W sum into 0 .. 2^PID_W-1 and flag which side clipped.
  function automatic sat_t sat_u(input logic signed [PID_SUM_W-1:0] sum);
    sat_t r;
    r.lo   = sum[PID_SUM_W-1];
    r.hi   = !sum[PID_SUM_W-1] && (sum[PID_SUM_W-2:PID_W] != '0);
    r.duty = r.hi ? '1 : (r.lo ? '0 : sum[PID_W-1:0]);
    return r;
  endfunction

endpackage

// File: rtl/pid_pwm_gen.sv
// PWM generator: free-running period counter, duty latched only at the period
// wrap so duty changes never glitch mid-period.
module pid_pwm_gen
  import pid_pkg::*;
#(
  parameter int W = PID_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] duty,
  output logic         pwm_out,
  output logic         period_start
);

  localparam logic [W-1:0] CNT_LAST = W'(2**W - 2);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  logic [W-1:0] duty_active;
  logic [W-1:0] duty_active_next;
  logic         wrap;
  logic         pwm_q;

  always_comb begin
    wrap             = (cnt == CNT_LAST);
    cnt_next         = wrap ? '0 : cnt + W'(1);
    duty_active_next = wrap ? duty : duty_active;
  end

  // pwm_q is computed from the next-state values so it stays aligned with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      duty_active <= '0;
      pwm_q       <= 1'b0;
    end else if (ena) begin
      cnt         <= cnt_next;
      duty_active <= duty_active_next;
      pwm_q       <= (cnt_next < duty_active_next);
    end
  end

  assign pwm_out = pwm_q;

  // Exactly one enabled cnt==0 cycle per period, including the first after reset.
  assign period_start = ena & ~rst & (cnt == '0);

endmodule

// File: rtl/pid_output_stage.sv
// PID output stage: sums p/i/d, clamps to an unsigned duty word with saturation
// flags, and drives a glitch-free PWM actuator.
module pid_output_stage
  import pid_pkg::*;
#(
  parameter int W     = PID_W,
  parameter int SUM_W = W + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  input  logic [W-1:0] p_contrib,
  input  logic [W-1:0] i_contrib,
  input  logic [W-1:0] d_contrib,
  output logic [W-1:0] duty,
  output logic         duty_valid,
  output logic         sat_hi,
  output logic         sat_lo,
  output logic         pwm_out,
  output logic         period_start
);

  logic [SUM_W-1:0] sum;
  logic             v1;
  logic [W-1:0]     duty_q;
  logic             sat_hi_q;
  logic             sat_lo_q;
  logic             dv_q;
  sat_t             sat;

  always_comb begin
    sat = sat_u(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      v1       <= 1'b0;
      duty_q   <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      dv_q     <= 1'b0;
    end else if (ena) begin
      v1   <= in_valid;
      dv_q <= v1;
      if (in_valid) begin
        sum <= {{(SUM_W-W){p_contrib[W-1]}}, p_contrib}
             + {{(SUM_W-W){i_contrib[W-1]}}, i_contrib}
             + {{(SUM_W-W){d_contrib[W-1]}}, d_contrib};
      end
      if (v1) begin
        duty_q   <= sat.duty;
        sat_hi_q <= sat.hi;
        sat_lo_q <= sat.lo;
      end
    end
  end

  assign duty       = duty_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;
  // The register freezes with ena low, so gate the pulse to keep it one enabled cycle.
  assign duty_valid = dv_q & ena;

  pid_pwm_gen #(.W(W)) u_pwm (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .duty         (duty_q),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

endmodule

// File: tb/tb_pid_output_stage.sv
// Self-checking bench for pid_output_stage: scoreboarded duty/saturation results
// and per-period PWM high-count / length measurement.
module tb_pid_output_stage;
  import pid_pkg::*;

  localparam int W      = PID_W;
  localparam int PERIOD = 2**W - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] p_contrib = '0;
  logic [W-1:0] i_contrib = '0;
  logic [W-1:0] d_contrib = '0;
  logic [W-1:0] duty;
  logic         duty_valid;
  logic         sat_hi;
  logic         sat_lo;
  logic         pwm_out;
  logic         period_start;

  always #5 clk = ~clk;

  pid_output_stage #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in_valid     (in_valid),
    .p_contrib    (p_contrib),
    .i_contrib    (i_contrib),
    .d_contrib    (d_contrib),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  typedef struct {
    int duty;
    int hi;
    int lo;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecyc = 0;
  int   period_done = 0;
  int   hi_cnt = 0;
  int   len_cnt = 0;
  int   last_high = 0;
  int   last_len = 0;
  bit   in_period = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Enabled-cycle counter used for latency expectations.
  always @(posedge clk) if (!rst && ena) ecyc <= ecyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (duty_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra_dv", 32'(duty_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("duty", 32'(duty), e.duty);
        chk("sat_hi", 32'(sat_hi), e.hi);
        chk("sat_lo", 32'(sat_lo), e.lo);
        chk("latency", ecyc, e.due);
      end
    end
    if (period_start) begin
      if (in_period) begin
        last_high = hi_cnt;
        last_len  = len_cnt;
        period_done++;
      end
      hi_cnt    = 0;
      len_cnt   = 0;
      in_period = 1;
    end
    len_cnt++;
    if (ena && pwm_out) hi_cnt++;
  end

  task automatic push_exp(input int p, input int i, input int d);
    exp_t e;
    int   s;
    s      = p + i + d;
    e.hi   = (s > PERIOD) ? 1 : 0;
    e.lo   = (s < 0) ? 1 : 0;
    e.duty = e.hi ? PERIOD : (e.lo ? 0 : s);
    e.due  = ecyc + 2;
    sb.push_back(e);
  endtask

  task automatic drive(input int p, input int i, input int d, input bit expect_out);
    in_valid  = 1'b1;
    p_contrib = W'(p);
    i_contrib = W'(i);
    d_contrib = W'(d);
    if (expect_out) push_exp(p, i, d);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int i, input int d);
    drive(p, i, d, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic expect_period(input string tag, input int exp_high, input int exp_len);
    int target;
    target = period_done + 1;
    for (int n = 0; n < 4 * PERIOD && period_done < target; n++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_tmo"}, 32'(period_done >= target), 1);
    chk({tag, "_high"}, last_high, exp_high);
    chk({tag, "_len"}, last_len, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", 32'(duty), 0);
    chk("rst_dv", 32'(duty_valid), 0);
    chk("rst_sat_hi", 32'(sat_hi), 0);
    chk("rst_sat_lo", 32'(sat_lo), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ps", 32'(period_start), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("first_ps", 32'(period_start), 1);
    chk("first_pwm", 32'(pwm_out), 0);

    // Nominal sample; applies from the next wrap.
    send(10, 5, -3);
    expect_period("p0", 0, PERIOD);
    expect_period("p1", 12, PERIOD);

    // Saturation both ways.
    send(31, 31, 31);
    expect_period("p2", 12, PERIOD);
    expect_period("p3", PERIOD, PERIOD);
    send(-32, -32, -32);
    expect_period("p4", PERIOD, PERIOD);
    expect_period("p5", 0, PERIOD);

    // duty_valid on the wrap edge: old duty latched, new one next period.
    send(10, 5, -3);
    expect_period("p6", 0, PERIOD);
    repeat (PERIOD - 2) @(posedge clk);
    #1;
    send(20, 10, 10);
    expect_period("p7", 12, PERIOD);
    expect_period("p8", 12, PERIOD);
    expect_period("p9", 40, PERIOD);

    // Back-to-back samples: only the last before the wrap applies.
    drive(5, 0, 0, 1'b1);
    drive(20, 20, 10, 1'b1);
    drive(11, 11, 11, 1'b1);
    in_valid = 1'b0;
    expect_period("p10", 40, PERIOD);
    expect_period("p11", 33, PERIOD);

    // ena low for 10 cycles with a sample sitting in stage 1.
    repeat (20) @(posedge clk);
    #1;
    send(10, 10, 0);
    ena = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("ena_lo_pwm", 32'(pwm_out), 1);
      chk("ena_lo_dv", 32'(duty_valid), 0);
      chk("ena_lo_ps", 32'(period_start), 0);
      @(posedge clk);
    end
    #1;
    ena = 1'b1;
    expect_period("p12", 33, PERIOD + 10);
    expect_period("p13", 20, PERIOD);

    // Reset mid-period with a sample in stage 1; that sample must never emerge.
    repeat (10) @(posedge clk);
    #1;
    drive(3, 2, 2, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_duty", 32'(duty), 0);
    chk("mrst_dv", 32'(duty_valid), 0);
    chk("mrst_sat_hi", 32'(sat_hi), 0);
    chk("mrst_sat_lo", 32'(sat_lo), 0);
    chk("mrst_pwm", 32'(pwm_out), 0);
    chk("mrst_ps", 32'(period_start), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_first_ps", 32'(period_start), 1);
    repeat (10) @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
